// File: rtl/majority_vote_sched.sv
// majority_vote_sched
// Arbitrates NUM_REQ vote requesters round-robin onto one shared, registered
// 3-input majority voter. The block returns each result with the requester id,
// a dissent flag, and a saturating count of delivered dissenting results.

module majority_vote_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3*NUM_REQ-1:0] req_vote,
    output logic                 vtr_a,
    output logic                 vtr_b,
    output logic                 vtr_c,
    input  logic                 vtr_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_z,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_dissent,
    output logic [CNT_W-1:0]     dissent_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // A triple dissents unless all three channels agree.
    function automatic logic is_dissent(input logic [2:0] t);
        return ~((t[0] == t[1]) && (t[1] == t[2]));
    endfunction

    state_t           state_r;
    logic [ID_W-1:0]  ptr_r;
    logic [2:0]       held_r;
    logic             rsp_valid_r;
    logic             rsp_z_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic             rsp_dissent_r;
    logic [CNT_W-1:0] dissent_cnt_r;
    logic             busy_r;

    logic [2:0]       vote_arr_s [NUM_REQ];
    logic             grant_found_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic [2:0]       grant_vote_s;
    logic [ID_W:0]    sum_s;
    logic [ID_W-1:0]  cand_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_vote_split
            assign vote_arr_s[gi] = req_vote[3*gi +: 3];
        end
    endgenerate

    // Round-robin search: walk from ptr+1 upward with wrap; the nearest valid requester wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sum_s         = '0;
        cand_s        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum_s = {1'b0, ptr_r} + (ID_W+1)'(k);
            if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
                cand_s = ID_W'(sum_s - (ID_W+1)'(NUM_REQ));
            end else begin
                cand_s = ID_W'(sum_s);
            end
            if (req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_vote_s = vote_arr_s[grant_idx_s];
    end

    // Accept strobe toward the winner; only offered while idle.
    always_comb begin
        req_ready = '0;
        if ((state_r == ST_IDLE) && grant_found_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Scheduler FSM: grant, drive voter, capture result, hand result back.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            ptr_r         <= ID_W'(NUM_REQ - 1);
            held_r        <= 3'b000;
            rsp_valid_r   <= 1'b0;
            rsp_z_r       <= 1'b0;
            rsp_id_r      <= '0;
            rsp_dissent_r <= 1'b0;
            dissent_cnt_r <= '0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        held_r   <= grant_vote_s;
                        rsp_id_r <= grant_idx_s;
                        ptr_r    <= grant_idx_s;
                        busy_r   <= 1'b1;
                        state_r  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_z_r       <= vtr_z;
                    rsp_dissent_r <= is_dissent(held_r);
                    rsp_valid_r   <= 1'b1;
                    state_r       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                        if (rsp_dissent_r && (dissent_cnt_r != {CNT_W{1'b1}})) begin
                            dissent_cnt_r <= dissent_cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign vtr_a       = held_r[0];
    assign vtr_b       = held_r[1];
    assign vtr_c       = held_r[2];
    assign rsp_valid   = rsp_valid_r;
    assign rsp_z       = rsp_z_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_dissent = rsp_dissent_r;
    assign dissent_cnt = dissent_cnt_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_majority_vote_sched.sv
// Testbench for majority_vote_sched: directed vectors plus multi-cycle
// sequences for round-robin order, backpressure, reset mid-flight and
// counter saturation (second instance with a 2-bit counter).

module tb_majority_vote_sched;

    logic        clk;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [11:0] req_vote;
    logic        rsp_ready;

    logic [3:0]  req_ready;
    logic        vtr_a, vtr_b, vtr_c, vtr_z;
    logic        rsp_valid, rsp_z, rsp_dissent, busy;
    logic [1:0]  rsp_id;
    logic [15:0] dissent_cnt;

    logic [3:0]  req_ready2;
    logic        vtr_a2, vtr_b2, vtr_c2, vtr_z2;
    logic        rsp_valid2, rsp_z2, rsp_dissent2, busy2;
    logic [1:0]  rsp_id2;
    logic [1:0]  dissent_cnt2;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt2;

    majority_vote_sched #(.NUM_REQ(4), .CNT_W(16)) u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_vote(req_vote), .vtr_a(vtr_a), .vtr_b(vtr_b), .vtr_c(vtr_c), .vtr_z(vtr_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_id(rsp_id),
        .rsp_dissent(rsp_dissent), .dissent_cnt(dissent_cnt), .busy(busy)
    );

    majority_vote_sched #(.NUM_REQ(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready2),
        .req_vote(req_vote), .vtr_a(vtr_a2), .vtr_b(vtr_b2), .vtr_c(vtr_c2), .vtr_z(vtr_z2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_z(rsp_z2), .rsp_id(rsp_id2),
        .rsp_dissent(rsp_dissent2), .dissent_cnt(dissent_cnt2), .busy(busy2)
    );

    // Shared registered voters, one per instance, reset with the scheduler.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vtr_z  <= 1'b0;
            vtr_z2 <= 1'b0;
        end else begin
            vtr_z  <= (vtr_a & vtr_b) | (vtr_b & vtr_c) | (vtr_a & vtr_c);
            vtr_z2 <= (vtr_a2 & vtr_b2) | (vtr_b2 & vtr_c2) | (vtr_a2 & vtr_c2);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [2:0] vote;
        logic       exp_z;
        logic       exp_dis;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_dissent();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
    endtask

    // Waits (bounded) for rsp_valid, sampling on falling edges.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
        check("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn    = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        req_vote  = 12'd0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_vtr", {vtr_c, vtr_b, vtr_a}, 0);
        check("rst_cnt", dissent_cnt, 0);
        check("rst_cnt2", dissent_cnt2, 0);
        exp_cnt  = 16'd0;
        exp_cnt2 = 2'd0;
        resetn   = 1'b1;
    endtask

    // One complete transaction from a single requester with rsp_ready held high.
    task automatic run_txn(input int idx, input logic [2:0] vote, input logic exp_z, input logic exp_dis);
        int lat;
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << idx;
        @(posedge clk); #1;
        req_vote  = 12'(vote) << (3 * idx);
        req_valid = exp_rdy;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("txn_req_ready", req_ready, exp_rdy);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_rsp(lat);
        check("txn_latency", lat, 3);
        check("txn_rsp_z", rsp_z, exp_z);
        check("txn_rsp_id", rsp_id, idx);
        check("txn_rsp_dissent", rsp_dissent, exp_dis);
        @(posedge clk); #1;
        if (exp_dis) model_dissent();
        @(negedge clk);
        check("txn_rsp_valid_low", rsp_valid, 0);
        check("txn_busy_low", busy, 0);
        check("txn_cnt", dissent_cnt, exp_cnt);
        check("txn_cnt2", dissent_cnt2, exp_cnt2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_ids [5];
        resetn    = 1'b0;
        req_valid = 4'b0000;
        req_vote  = 12'd0;
        rsp_ready = 1'b0;
        exp_cnt   = 16'd0;
        exp_cnt2  = 2'd0;

        // {requester, triple {c,b,a}, majority, dissent}
        vecs[0] = '{0, 3'b011, 1'b1, 1'b1};
        vecs[1] = '{2, 3'b111, 1'b1, 1'b0};
        vecs[2] = '{3, 3'b000, 1'b0, 1'b0};
        vecs[3] = '{1, 3'b101, 1'b1, 1'b1};
        vecs[4] = '{3, 3'b100, 1'b0, 1'b1};
        vecs[5] = '{0, 3'b110, 1'b1, 1'b1};
        vecs[6] = '{2, 3'b010, 1'b0, 1'b1};
        vecs[7] = '{1, 3'b001, 1'b0, 1'b1};

        apply_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].idx, vecs[i].vote, vecs[i].exp_z, vecs[i].exp_dis);
        end

        // All four requesters held valid: grants 0,1,2,3,0 at one per 4 cycles.
        apply_reset();
        exp_ids = '{0, 1, 2, 3, 0};
        req_vote  = {4{3'b111}};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(lat);
            check("rr_rsp_id", rsp_id, exp_ids[k]);
            check("rr_rsp_z", rsp_z, 1);
            check("rr_spacing", lat, (k == 0) ? 3 : 4);
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;

        // Backpressure: result held for 5 cycles while req0 waits unserved.
        @(posedge clk); #1;
        req_vote  = 12'b000_000_110_001;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_req_ready_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        wait_rsp(lat);
        for (int j = 0; j < 5; j++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_z", rsp_z, 1);
            check("bp_rsp_id", rsp_id, 1);
            check("bp_rsp_dissent", rsp_dissent, 1);
            check("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        model_dissent();
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_rsp_valid", rsp_valid, 0);
        check("bp_idle_req_ready", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_rsp(lat);
        check("bp2_rsp_id", rsp_id, 0);
        check("bp2_rsp_z", rsp_z, 0);
        check("bp2_rsp_dissent", rsp_dissent, 1);
        @(posedge clk); #1;
        model_dissent();
        @(negedge clk);
        check("bp_cnt", dissent_cnt, exp_cnt);
        check("bp_cnt2", dissent_cnt2, exp_cnt2);

        // Reset pulsed during CAPTURE: the in-flight vote is discarded.
        @(posedge clk); #1;
        req_vote  = 12'b000_011_000_000;
        req_valid = 4'b0100;
        @(negedge clk);
        check("r6_req_ready", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("r6_busy_issue", busy, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        exp_cnt  = 16'd0;
        exp_cnt2 = 2'd0;
        check("r6_rsp_valid", rsp_valid, 0);
        check("r6_busy", busy, 0);
        check("r6_vtr", {vtr_c, vtr_b, vtr_a}, 0);
        check("r6_rsp_id", rsp_id, 0);
        check("r6_cnt", dissent_cnt, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("r6_no_rsp", rsp_valid, 0);
        end
        req_vote  = 12'b000_000_000_111;
        req_valid = 4'b0011;
        #1;
        check("r6_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_rsp(lat);
        check("r6_latency", lat, 3);
        check("r6_rsp_id0", rsp_id, 0);
        check("r6_rsp_z", rsp_z, 1);
        @(posedge clk); #1;

        // Saturation of the 2-bit counter: 1,2,3,3,3.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 3'b001, 1'b0, 1'b1);
        end
        check("sat_cnt2_final", dissent_cnt2, 3);
        check("sat_cnt_final", dissent_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
